// File: rtl/board_input_ctrl.sv
// rtl/board_input_ctrl.sv - push-button conditioning, cursor/selection FSM and move request handshake

// Two-flop synchroniser plus stable-level debounce for one raw button.
// Emits a single-cycle press pulse when the accepted level goes 0->1.
module btn_debounce #(
    parameter int CYCLES = 120000
) (
    input  logic clk12,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] cnt;

    // Synchronise the raw level, count consecutive disagreeing cycles, flip the stable level on reaching the limit.
    always_ff @(posedge clk12) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_b;
                cnt    <= '0;
                press  <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// Converts debounced button events into cursor moves, piece selection and a move request to game logic.
module board_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int FOUND_WAIT      = 2
) (
    input  logic       clk12,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       btn_esc,
    input  logic       found_piece,
    input  logic       move_ack,
    output logic [5:0] cursor,
    output logic       enter_pressed,
    output logic       esc_pressed,
    output logic       confirm_pressed,
    output logic [5:0] src_sq,
    output logic [5:0] dst_sq,
    output logic       move_req
);
    localparam logic [1:0] ST_BROWSE     = 2'd0;
    localparam logic [1:0] ST_WAIT_FOUND = 2'd1;
    localparam logic [1:0] ST_SELECTED   = 2'd2;
    localparam logic [1:0] ST_CONFIRM    = 2'd3;

    localparam int WW = (FOUND_WAIT < 1) ? 1 : $clog2(FOUND_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(FOUND_WAIT);

    // Bit order of the button vectors: up, down, left, right, enter, esc.
    logic [5:0] raw_btn;
    logic [5:0] btn_press;

    assign raw_btn = {btn_esc, btn_enter, btn_right, btn_left, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_db
            btn_debounce #(
                .CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk12 (clk12),
                .reset (reset),
                .raw   (raw_btn[gi]),
                .press (btn_press[gi])
            );
        end
    endgenerate

    logic ev_up;
    logic ev_down;
    logic ev_left;
    logic ev_right;
    logic ev_enter;
    logic ev_esc;

    assign ev_up    = btn_press[0];
    assign ev_down  = btn_press[1];
    assign ev_left  = btn_press[2];
    assign ev_right = btn_press[3];
    assign ev_enter = btn_press[4];
    assign ev_esc   = btn_press[5];

    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [2:0]    cur_row;
    logic [2:0]    cur_col;
    logic [2:0]    moved_row;
    logic [2:0]    moved_col;
    logic [5:0]    moved_cursor;

    assign cur_row      = cursor[5:3];
    assign cur_col      = cursor[2:0];
    assign moved_cursor = {moved_row, moved_col};

    // Saturating cursor step; opposing arrows in the same cycle cancel on their axis.
    always_comb begin
        moved_row = cur_row;
        moved_col = cur_col;
        if (ev_up && !ev_down && (cur_row != 3'd7)) begin
            moved_row = cur_row + 3'd1;
        end else if (ev_down && !ev_up && (cur_row != 3'd0)) begin
            moved_row = cur_row - 3'd1;
        end
        if (ev_right && !ev_left && (cur_col != 3'd7)) begin
            moved_col = cur_col + 3'd1;
        end else if (ev_left && !ev_right && (cur_col != 3'd0)) begin
            moved_col = cur_col - 3'd1;
        end
    end

    // Selection FSM; esc outranks enter, which outranks arrows, and ack outranks esc while confirming.
    always_ff @(posedge clk12) begin
        if (reset) begin
            state           <= ST_BROWSE;
            wait_cnt        <= '0;
            cursor          <= 6'd0;
            enter_pressed   <= 1'b0;
            esc_pressed     <= 1'b0;
            confirm_pressed <= 1'b0;
            src_sq          <= 6'd0;
            dst_sq          <= 6'd0;
            move_req        <= 1'b0;
        end else begin
            esc_pressed <= 1'b0;
            case (state)
                ST_BROWSE: begin
                    if (ev_esc) begin
                        esc_pressed <= 1'b1;
                    end else if (ev_enter) begin
                        state         <= ST_WAIT_FOUND;
                        enter_pressed <= 1'b1;
                        wait_cnt      <= '0;
                    end else begin
                        cursor <= moved_cursor;
                    end
                end
                ST_WAIT_FOUND: begin
                    if (ev_esc) begin
                        state         <= ST_BROWSE;
                        enter_pressed <= 1'b0;
                        esc_pressed   <= 1'b1;
                    end else if (wait_cnt == WAIT_MAX) begin
                        // The display needs a few cycles to look up the square before found_piece is valid.
                        if (found_piece) begin
                            state  <= ST_SELECTED;
                            src_sq <= cursor;
                        end else begin
                            state         <= ST_BROWSE;
                            enter_pressed <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_SELECTED: begin
                    if (ev_esc) begin
                        state         <= ST_BROWSE;
                        enter_pressed <= 1'b0;
                        esc_pressed   <= 1'b1;
                    end else if (ev_enter) begin
                        // Dropping a piece back on its own square is not a move.
                        if (cursor != src_sq) begin
                            state           <= ST_CONFIRM;
                            dst_sq          <= cursor;
                            confirm_pressed <= 1'b1;
                            move_req        <= 1'b1;
                        end
                    end else begin
                        cursor <= moved_cursor;
                    end
                end
                default: begin
                    if (move_ack) begin
                        state           <= ST_BROWSE;
                        move_req        <= 1'b0;
                        confirm_pressed <= 1'b0;
                        enter_pressed   <= 1'b0;
                    end else if (ev_esc) begin
                        state           <= ST_SELECTED;
                        confirm_pressed <= 1'b0;
                        move_req        <= 1'b0;
                        dst_sq          <= 6'd0;
                        esc_pressed     <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_input_ctrl.sv
// tb/tb_board_input_ctrl.sv - scoreboard bench for board_input_ctrl with a behavioural reference model
module tb_board_input_ctrl;
    localparam int DEB = 4;
    localparam int FW  = 2;
    localparam int LAT = 2 + DEB + 1;

    localparam logic [5:0] B_UP    = 6'b000001;
    localparam logic [5:0] B_DOWN  = 6'b000010;
    localparam logic [5:0] B_LEFT  = 6'b000100;
    localparam logic [5:0] B_RIGHT = 6'b001000;
    localparam logic [5:0] B_ENTER = 6'b010000;
    localparam logic [5:0] B_ESC   = 6'b100000;

    localparam int M_BROWSE   = 0;
    localparam int M_SELECTED = 2;
    localparam int M_CONFIRM  = 3;

    logic       clk12 = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_enter = 1'b0, btn_esc = 1'b0;
    logic       found_piece = 1'b0;
    logic       move_ack = 1'b0;
    logic [5:0] cursor, src_sq, dst_sq;
    logic       enter_pressed, esc_pressed, confirm_pressed, move_req;

    board_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .FOUND_WAIT      (FW)
    ) dut (
        .clk12           (clk12),
        .reset           (reset),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_enter       (btn_enter),
        .btn_esc         (btn_esc),
        .found_piece     (found_piece),
        .move_ack        (move_ack),
        .cursor          (cursor),
        .enter_pressed   (enter_pressed),
        .esc_pressed     (esc_pressed),
        .confirm_pressed (confirm_pressed),
        .src_sq          (src_sq),
        .dst_sq          (dst_sq),
        .move_req        (move_req)
    );

    initial forever #5 clk12 = ~clk12;

    int          total = 0;
    int          passed = 0;
    logic [21:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic [21:0] prev_obs;
    int          ent_hi = 0;
    int          esc_hi = 0;

    // Reference model state: the board as the user sees it.
    int          m_mode = M_BROWSE;
    int          m_row = 0, m_col = 0;
    logic        m_ent = 1'b0, m_esc = 1'b0, m_conf = 1'b0, m_req = 1'b0;
    logic [5:0]  m_src = 6'd0, m_dst = 6'd0;
    logic [21:0] m_last = 22'd0;

    function automatic logic [21:0] dut_snap();
        return {cursor, enter_pressed, esc_pressed, confirm_pressed, src_sq, dst_sq, move_req};
    endfunction

    function automatic logic [5:0] m_cur();
        logic [2:0] r, c;
        r = m_row[2:0];
        c = m_col[2:0];
        return {r, c};
    endfunction

    function automatic logic [21:0] m_snap();
        return {m_cur(), m_ent, m_esc, m_conf, m_src, m_dst, m_req};
    endfunction

    task automatic emit();
        logic [21:0] s;
        s = m_snap();
        if (s !== m_last) exp_q.push_back(s);
        m_last = s;
    endtask

    task automatic m_move(input logic [5:0] m);
        if (m[0] && !m[1]) m_row = (m_row + 1 > 7) ? 7 : m_row + 1;
        if (m[1] && !m[0]) m_row = (m_row - 1 < 0) ? 0 : m_row - 1;
        if (m[3] && !m[2]) m_col = (m_col + 1 > 7) ? 7 : m_col + 1;
        if (m[2] && !m[3]) m_col = (m_col - 1 < 0) ? 0 : m_col - 1;
    endtask

    task automatic m_esc_pulse();
        m_esc = 1'b1;
        emit();
        m_esc = 1'b0;
        emit();
    endtask

    // Predict the sequence of output changes produced by one simultaneous set of button events.
    task automatic model_events(input logic [5:0] m, input bit f);
        if (m_mode == M_BROWSE) begin
            if (m[5]) begin
                m_esc_pulse();
            end else if (m[4]) begin
                m_ent = 1'b1;
                emit();
                if (f) begin
                    m_src  = m_cur();
                    m_mode = M_SELECTED;
                    emit();
                end else begin
                    m_ent = 1'b0;
                    emit();
                end
            end else begin
                m_move(m);
                emit();
            end
        end else if (m_mode == M_SELECTED) begin
            if (m[5]) begin
                m_mode = M_BROWSE;
                m_ent  = 1'b0;
                m_esc_pulse();
            end else if (m[4]) begin
                if (m_cur() != m_src) begin
                    m_dst  = m_cur();
                    m_conf = 1'b1;
                    m_req  = 1'b1;
                    m_mode = M_CONFIRM;
                    emit();
                end
            end else begin
                m_move(m);
                emit();
            end
        end else begin
            if (m[5]) begin
                m_mode = M_SELECTED;
                m_conf = 1'b0;
                m_req  = 1'b0;
                m_dst  = 6'd0;
                m_esc_pulse();
            end
        end
    endtask

    task automatic model_ack();
        if (m_mode == M_CONFIRM) begin
            m_mode = M_BROWSE;
            m_ent  = 1'b0;
            m_conf = 1'b0;
            m_req  = 1'b0;
            emit();
        end
    endtask

    task automatic model_reset();
        m_mode = M_BROWSE;
        m_row  = 0;
        m_col  = 0;
        m_ent  = 1'b0;
        m_esc  = 1'b0;
        m_conf = 1'b0;
        m_req  = 1'b0;
        m_src  = 6'd0;
        m_dst  = 6'd0;
        emit();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_btns(input logic [5:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_left  = m[2];
        btn_right = m[3];
        btn_enter = m[4];
        btn_esc   = m[5];
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk12);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expected output changes still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic press(input logic [5:0] m, input bit f, input int hold);
        found_piece = f;
        model_events(m, f);
        @(posedge clk12);
        #1 set_btns(m);
        repeat (hold) @(posedge clk12);
        #1 set_btns(6'd0);
        repeat (12) @(posedge clk12);
        drain();
    endtask

    task automatic glitch(input logic [5:0] m, input int len);
        @(posedge clk12);
        #1 set_btns(m);
        repeat (len) @(posedge clk12);
        #1 set_btns(6'd0);
        repeat (12) @(posedge clk12);
        drain();
    endtask

    task automatic ack_pulse();
        model_ack();
        @(posedge clk12);
        #1 move_ack = 1'b1;
        @(posedge clk12);
        #1 move_ack = 1'b0;
        repeat (3) @(posedge clk12);
        drain();
    endtask

    // Monitor: every change of the output bundle must match the next predicted change.
    initial begin
        logic [21:0] obs;
        logic [21:0] e;
        forever begin
            @(negedge clk12);
            if (mon_en) begin
                obs = dut_snap();
                if (enter_pressed) ent_hi++;
                if (esc_pressed) esc_hi++;
                if (obs !== prev_obs) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL monitor: unexpected output change to %h, expected no change from %h", obs, prev_obs);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs === e) passed++;
                        else $display("FAIL monitor: outputs %h, expected %h", obs, e);
                    end
                    prev_obs = obs;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [5:0] mk;
        bit f;

        repeat (3) @(posedge clk12);
        #1 reset = 1'b0;
        @(negedge clk12);
        check("reset_state", int'(dut_snap()), 0);
        prev_obs = dut_snap();
        m_last   = 22'd0;
        mon_en   = 1'b1;

        press(B_UP, 1'b0, 20);
        check("up_once", int'(cursor), 8);
        glitch(B_RIGHT, 3);
        check("glitch_ignored", int'(cursor), 8);

        repeat (6) press(B_UP, 1'b0, 12);
        repeat (7) press(B_RIGHT, 1'b0, 12);
        check("corner_max", int'(cursor), 63);
        press(B_UP, 1'b0, 12);
        press(B_RIGHT, 1'b0, 12);
        check("saturate_max", int'(cursor), 63);
        repeat (7) press(B_DOWN, 1'b0, 12);
        repeat (7) press(B_LEFT, 1'b0, 12);
        press(B_DOWN | B_LEFT, 1'b0, 12);
        check("saturate_min", int'(cursor), 0);
        press(B_UP | B_RIGHT, 1'b0, 12);
        check("diagonal", int'(cursor), 9);

        repeat (3) press(B_RIGHT, 1'b0, 12);
        check("cursor_12", int'(cursor), 12);
        press(B_ENTER, 1'b1, 12);
        check("src_latched", int'(src_sq), 12);
        check("enter_held", int'(enter_pressed), 1);
        repeat (2) press(B_UP, 1'b0, 12);
        press(B_ENTER, 1'b1, 12);
        check("dst_latched", int'(dst_sq), 28);
        check("req_raised", int'({confirm_pressed, move_req}), 3);
        ack_pulse();
        check("ack_clears", int'({enter_pressed, confirm_pressed, move_req}), 0);
        check("ack_keeps_sq", int'({src_sq, dst_sq}), (12 << 6) | 28);

        ent_hi = 0;
        press(B_ENTER, 1'b0, 12);
        check("enter_no_piece_len", ent_hi, FW + 1);

        press(B_ENTER, 1'b1, 12);
        press(B_DOWN, 1'b0, 12);
        press(B_ENTER, 1'b1, 12);
        esc_hi = 0;
        press(B_ESC, 1'b0, 12);
        check("esc_pulse_len", esc_hi, 1);
        check("esc_back_to_selected", int'({enter_pressed, confirm_pressed, move_req, dst_sq}), 1 << 8);
        press(B_ESC, 1'b0, 12);
        check("esc_to_browse", int'(enter_pressed), 0);

        press(B_ENTER, 1'b1, 12);
        press(B_LEFT, 1'b0, 12);
        press(B_ENTER, 1'b1, 12);
        esc_hi = 0;
        model_ack();
        @(posedge clk12);
        #1 btn_esc = 1'b1;
        repeat (LAT) @(posedge clk12);
        #1 move_ack = 1'b1;
        @(posedge clk12);
        #1 move_ack = 1'b0;
        repeat (4) @(posedge clk12);
        #1 btn_esc = 1'b0;
        repeat (12) @(posedge clk12);
        drain();
        check("ack_beats_esc", esc_hi, 0);
        check("ack_beats_esc_flags", int'({enter_pressed, confirm_pressed, move_req}), 0);
        check("ack_beats_esc_dst", int'(dst_sq), 19);

        press(B_ENTER, 1'b1, 12);
        press(B_RIGHT, 1'b0, 12);
        press(B_ENTER, 1'b1, 12);
        @(posedge clk12);
        #1 btn_up = 1'b1;
        repeat (12) @(posedge clk12);
        model_reset();
        model_events(B_UP, 1'b0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk12);
        #1 reset = 1'b0;
        repeat (15) @(posedge clk12);
        #1 btn_up = 1'b0;
        repeat (12) @(posedge clk12);
        drain();
        check("reset_then_held_up", int'(cursor), 8);
        check("reset_clears_sq", int'({src_sq, dst_sq}), 0);

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            f  = 1'($urandom_range(0, 1));
            if (op <= 5) begin
                mk = 6'd1 << op;
                press(mk, f, 12);
            end else if (op == 6) begin
                mk = 6'($urandom_range(1, 15));
                press(mk, f, 12);
            end else if (op == 7) begin
                mk = 6'($urandom_range(1, 63));
                press(mk, f, 12);
            end else if (op == 8) begin
                mk = 6'($urandom_range(1, 63));
                glitch(mk, $urandom_range(1, DEB - 1));
            end else begin
                ack_pulse();
            end
        end
        check("random_final_cursor", int'(cursor), int'(m_cur()));

        repeat (5) @(posedge clk12);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
